// File: rtl/mem_write_responder_if.sv
// Client-side line-write bus between a requester (master) and the memory responder (slave).
// Latency: the header and first line are presented together; the responder grants no earlier than the next cycle.
// Backpressure: the master holds mem_data/last/mem_last_valid stable until it sees mem_gnt.
interface mem_write_responder_if #(
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int ADDR_WIDTH        = 19
);
    localparam int LW = $clog2(NUM_WORDS_IN_LINE);

    logic                                      mem_req;
    logic [ADDR_WIDTH-1:0]                     mem_start_addr;
    logic [ADDR_WIDTH-1:0]                     mem_size_bytes;
    logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0]   mem_data;
    logic                                      last;
    logic [LW-1:0]                             mem_last_valid;
    logic                                      mem_gnt;

    modport master (
        output mem_req, mem_start_addr, mem_size_bytes, mem_data, last, mem_last_valid,
        input  mem_gnt
    );

    modport slave (
        input  mem_req, mem_start_addr, mem_size_bytes, mem_data, last, mem_last_valid,
        output mem_gnt
    );
endinterface

// File: rtl/mem_write_responder.sv
// Memory-side endpoint: accepts line bursts, stages one line, drains it to a line-wide SRAM port.
// Latency: header to first grant 1 cycle; handshake to sram_we 1 cycle; one line per cycle sustained.
// Backpressure: mem_gnt drops while the staging buffer is full and the SRAM is not ready.
module mem_write_responder #(
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int ADDR_WIDTH        = 19,
    localparam int LW  = $clog2(NUM_WORDS_IN_LINE),
    localparam int LAW = ADDR_WIDTH - LW,
    localparam int DW  = NUM_WORDS_IN_LINE * WORD_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mem_write_responder_if.slave          bus,
    output logic                          o_sram_we,
    input  logic                          i_sram_ready,
    output logic [LAW-1:0]                o_sram_addr,
    output logic [DW-1:0]                 o_sram_wdata,
    output logic [NUM_WORDS_IN_LINE-1:0]  o_sram_be,
    output logic                          o_busy,
    output logic                          o_wr_done,
    output logic                          o_err_len,
    output logic                          o_err_align
);
    // Byte-granular enables only make sense with 8-bit words.
    if (WORD_WIDTH != 8) begin : g_bad_word_width
        $error("mem_write_responder: WORD_WIDTH must be 8");
    end

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t                         r_state;
    logic [LAW-1:0]                 r_line_ptr;
    logic [LAW:0]                   r_lines_left;
    logic [LW-1:0]                  r_exp_lv;
    logic                           r_err_len;
    logic                           r_err_align;

    logic                           r_buf_valid;
    logic                           r_is_final;
    logic [LAW-1:0]                 r_sram_addr;
    logic [DW-1:0]                  r_sram_wdata;
    logic [NUM_WORDS_IN_LINE-1:0]   r_sram_be;
    logic                           r_wr_done;

    logic                           w_gnt;
    logic                           w_drain;
    logic                           w_final;
    logic                           w_err_len;
    logic                           w_size_zero;
    logic                           w_misaligned;
    logic [ADDR_WIDTH:0]            w_size_rnd;
    logic [LAW:0]                   w_lines_calc;
    logic [LW-1:0]                  w_exp_lv;
    logic [NUM_WORDS_IN_LINE-1:0]   w_be;

    // Grant whenever the buffer is free or is being drained this same edge.
    assign w_gnt   = (r_state == S_BURST) && bus.mem_req && (!r_buf_valid || i_sram_ready);
    assign w_drain = r_buf_valid && i_sram_ready;

    // A line ends the burst on client last or when the byte count runs out, whichever first.
    assign w_final   = bus.last || (r_lines_left == (LAW+1)'(1));
    assign w_err_len = (bus.last && (r_lines_left > (LAW+1)'(1)))
                    || (!bus.last && (r_lines_left == (LAW+1)'(1)))
                    || (w_final && (bus.mem_last_valid != r_exp_lv));

    // Header decode: zero size is treated as one full line.
    assign w_size_zero  = (bus.mem_size_bytes == '0);
    assign w_misaligned = (bus.mem_start_addr[LW-1:0] != '0);
    assign w_size_rnd   = {1'b0, bus.mem_size_bytes} + (ADDR_WIDTH+1)'(NUM_WORDS_IN_LINE - 1);
    assign w_lines_calc = w_size_zero ? (LAW+1)'(1) : w_size_rnd[ADDR_WIDTH:LW];
    assign w_exp_lv     = bus.mem_size_bytes[LW-1:0] - LW'(1);

    // Word enables: final line is truncated at the client's last valid word.
    always_comb begin
        w_be = '1;
        if (w_final) begin
            for (int i = 0; i < NUM_WORDS_IN_LINE; i++) begin
                w_be[i] = (LW'(i) <= bus.mem_last_valid);
            end
        end
    end

    // Burst FSM: header capture in IDLE, line counting and error pulses in BURST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_line_ptr   <= '0;
            r_lines_left <= '0;
            r_exp_lv     <= '0;
            r_err_len    <= 1'b0;
            r_err_align  <= 1'b0;
        end else begin
            r_err_len   <= 1'b0;
            r_err_align <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.mem_req) begin
                        r_line_ptr   <= bus.mem_start_addr[ADDR_WIDTH-1:LW];
                        r_lines_left <= w_lines_calc;
                        r_exp_lv     <= w_exp_lv;
                        r_err_align  <= w_misaligned || w_size_zero;
                        r_state      <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_gnt) begin
                        r_line_ptr   <= r_line_ptr + LAW'(1);
                        r_lines_left <= r_lines_left - (LAW+1)'(1);
                        r_err_len    <= w_err_len;
                        if (w_final) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Single-entry staging buffer; a handshake on the drain edge replaces the line in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid  <= 1'b0;
            r_is_final   <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_sram_be    <= '0;
            r_wr_done    <= 1'b0;
        end else begin
            r_wr_done <= w_drain && r_is_final;
            if (w_gnt) begin
                r_buf_valid  <= 1'b1;
                r_is_final   <= w_final;
                r_sram_addr  <= r_line_ptr;
                r_sram_wdata <= bus.mem_data;
                r_sram_be    <= w_be;
            end else if (w_drain) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign bus.mem_gnt  = w_gnt;
    assign o_sram_we    = r_buf_valid;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_wdata = r_sram_wdata;
    assign o_sram_be    = r_sram_be;
    assign o_busy       = (r_state == S_BURST) || r_buf_valid;
    assign o_wr_done    = r_wr_done;
    assign o_err_len    = r_err_len;
    assign o_err_align  = r_err_align;
endmodule

// File: tb/tb_mem_write_responder.sv
// Bench for mem_write_responder: random and directed bursts against a burst-level reference model.
// Latency: expected SRAM writes are queued per burst and popped by an independent monitor.
// Backpressure: sram_ready is driven always-high, random, or forced low.
module tb_mem_write_responder;
    localparam int WW  = 8;
    localparam int NW  = 32;
    localparam int AW  = 19;
    localparam int LW  = 5;
    localparam int LAW = AW - LW;
    localparam int DW  = NW * WW;

    typedef struct {
        logic [LAW-1:0] addr;
        logic [DW-1:0]  data;
        logic [NW-1:0]  be;
        bit             fin;
    } wr_t;

    logic            clk;
    logic            rst_n;
    logic            i_sram_ready;
    logic            o_sram_we;
    logic [LAW-1:0]  o_sram_addr;
    logic [DW-1:0]   o_sram_wdata;
    logic [NW-1:0]   o_sram_be;
    logic            o_busy;
    logic            o_wr_done;
    logic            o_err_len;
    logic            o_err_align;

    mem_write_responder_if #(.WORD_WIDTH(WW), .NUM_WORDS_IN_LINE(NW), .ADDR_WIDTH(AW)) bus_if ();

    mem_write_responder #(.WORD_WIDTH(WW), .NUM_WORDS_IN_LINE(NW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus_if),
        .o_sram_we    (o_sram_we),
        .i_sram_ready (i_sram_ready),
        .o_sram_addr  (o_sram_addr),
        .o_sram_wdata (o_sram_wdata),
        .o_sram_be    (o_sram_be),
        .o_busy       (o_busy),
        .o_wr_done    (o_wr_done),
        .o_err_len    (o_err_len),
        .o_err_align  (o_err_align)
    );

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  ready_mode = 0;
    int  exp_err_len = 0;
    int  exp_err_align = 0;
    int  seen_err_len = 0;
    int  seen_err_align = 0;
    int  first_gnt_c;
    int  last_gnt_c;
    int  burst_start_cyc;
    int  last_done_cyc = -1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int calc_lines(input int sz);
        return (sz == 0) ? 1 : (sz + NW - 1) / NW;
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // SRAM-side ready: 0 = always ready, 1 = random, otherwise stalled.
    initial begin
        i_sram_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       i_sram_ready = 1'b1;
                1:       i_sram_ready = ($urandom_range(3) != 0);
                default: i_sram_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every SRAM write, checks wr_done timing and stall grants.
    initial begin
        bit  done_due;
        wr_t e;
        done_due = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_due = 0;
            end else begin
                checks++;
                if (o_wr_done !== done_due) begin
                    errors++;
                    $display("FAIL wr_done: got %b expected %b at cycle %0d", o_wr_done, done_due, cyc);
                end
                if (o_wr_done) last_done_cyc = cyc;
                if (o_err_len)   seen_err_len++;
                if (o_err_align) seen_err_align++;
                done_due = 0;
                if (o_sram_we && !i_sram_ready) begin
                    checks++;
                    if (bus_if.mem_gnt !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_gnt: got %b expected 0 at cycle %0d", bus_if.mem_gnt, cyc);
                    end
                end
                if (o_sram_we && i_sram_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sram_write: got unexpected write addr %0h expected none", o_sram_addr);
                    end else begin
                        e = sb.pop_front();
                        if (o_sram_addr !== e.addr || o_sram_wdata !== e.data || o_sram_be !== e.be) begin
                            errors++;
                            $display("FAIL sram_write: got addr %0h be %0h data %0h expected addr %0h be %0h data %0h",
                                     o_sram_addr, o_sram_be, o_sram_wdata, e.addr, e.be, e.data);
                        end
                        done_due = e.fin;
                    end
                end
            end
        end
    end

    // One burst as a client would issue it; last_at is the 1-based line carrying last (0 = never).
    // Expected writes and error pulses come from the byte count and the client's last/last_valid choices.
    task automatic run_burst(input logic [AW-1:0] start, input logic [AW-1:0] size,
                             input int last_at, input logic [LW-1:0] lv);
        int            lines, nwr, k, c, base, sz;
        logic [LW-1:0] elv;
        logic [63:0]   m;
        logic [DW-1:0] dq[$];
        wr_t           e;
        bit            hs;
        sz    = int'(size);
        lines = calc_lines(sz);
        elv   = (sz == 0) ? LW'(NW - 1) : LW'((sz - 1) % NW);
        nwr   = (last_at >= 1 && last_at < lines) ? last_at : lines;
        base  = int'(start) / NW;
        if (last_at != lines || lv != elv) exp_err_len++;
        if (start[LW-1:0] != '0 || sz == 0) exp_err_align++;
        m = (64'd1 << (int'(lv) + 1)) - 64'd1;
        for (int i = 0; i < nwr; i++) begin
            e.addr = LAW'(base + i);
            e.data = rand_line();
            e.fin  = (i == nwr - 1);
            e.be   = e.fin ? m[NW-1:0] : '1;
            sb.push_back(e);
            dq.push_back(e.data);
        end
        burst_start_cyc = cyc;
        first_gnt_c = -1;
        last_gnt_c  = -1;
        bus_if.mem_req        = 1'b1;
        bus_if.mem_start_addr = start;
        bus_if.mem_size_bytes = size;
        bus_if.mem_last_valid = lv;
        k = 0;
        c = 0;
        forever begin
            bus_if.mem_data = dq[k];
            bus_if.last     = (k == last_at - 1);
            @(negedge clk);
            hs = bus_if.mem_gnt;
            if (hs) begin
                if (first_gnt_c < 0) first_gnt_c = c;
                last_gnt_c = c;
            end
            @(posedge clk);
            #1;
            c++;
            if (hs) begin
                k++;
                if (k == nwr) break;
            end
            if (c > 2000) begin
                checks++;
                errors++;
                $display("FAIL burst_timeout: got %0d grants expected %0d", k, nwr);
                break;
            end
        end
        bus_if.mem_req = 1'b0;
        bus_if.last    = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 1000; i++) begin
            if (sb.size() == 0 && !o_busy) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0 || o_busy) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending lines busy %b expected 0 pending", name, sb.size(), o_busy);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_errs(input string name);
        chk({name, "_err_len"},   seen_err_len,   exp_err_len);
        chk({name, "_err_align"}, seen_err_align, exp_err_align);
    endtask

    initial begin
        int            sz, lines, la, sel;
        logic [AW-1:0] st;
        logic [LW-1:0] lv, elv;

        rst_n                 = 1'b0;
        bus_if.mem_req        = 1'b0;
        bus_if.mem_start_addr = '0;
        bus_if.mem_size_bytes = '0;
        bus_if.mem_data       = '0;
        bus_if.last           = 1'b0;
        bus_if.mem_last_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt",       bus_if.mem_gnt, 0);
        chk("rst_sram_we",   o_sram_we, 0);
        chk("rst_busy",      o_busy, 0);
        chk("rst_wr_done",   o_wr_done, 0);
        chk("rst_err_len",   o_err_len, 0);
        chk("rst_err_align", o_err_align, 0);
        chk("rst_addr",      o_sram_addr, 0);
        chk("rst_wdata",     o_sram_wdata, 0);
        chk("rst_be",        o_sram_be, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Aligned 3-line burst with grant and completion timing.
        run_burst(19'h00400, 19'd96, 3, 5'd31);
        chk("t1_first_gnt_cycle", first_gnt_c, 1);
        chk("t1_last_gnt_cycle",  last_gnt_c, 3);
        wait_drain("t1");
        chk("t1_wr_done_cycle", last_done_cyc - burst_start_cyc, 5);
        check_errs("t1");

        // Partial final line.
        run_burst(19'h00800, 19'd70, 3, 5'd5);
        wait_drain("t2");
        check_errs("t2");

        // Backpressure mid-burst.
        fork
            run_burst(19'h01000, 19'd256, 8, 5'd31);
            begin
                repeat (3) @(posedge clk);
                ready_mode = 2;
                repeat (4) @(posedge clk);
                ready_mode = 0;
            end
        join
        wait_drain("t3");
        check_errs("t3");

        // Early last, misaligned start, zero size, missing last, pointer wrap.
        run_burst(19'h02000, 19'd128, 2, 5'd31);
        run_burst(19'h00410, 19'd32, 1, 5'd31);
        run_burst(19'h00000, 19'd0, 1, 5'd31);
        run_burst(19'h03000, 19'd64, 0, 5'd31);
        run_burst(19'h7FFC0, 19'd96, 3, 5'd31);
        wait_drain("t4");
        check_errs("t4");

        // Random back-to-back bursts with random SRAM readiness.
        ready_mode = 1;
        for (int n = 0; n < 30; n++) begin
            sz = $urandom_range(320, 1);
            if ($urandom_range(9) == 0) sz = 0;
            st = AW'($urandom);
            if ($urandom_range(4) != 0) st[LW-1:0] = '0;
            lines = calc_lines(sz);
            sel = $urandom_range(5);
            la = (sel == 0) ? lines - 1 : (sel == 1) ? lines + 1 : (sel == 2) ? 0 : lines;
            elv = (sz == 0) ? LW'(NW - 1) : LW'((sz - 1) % NW);
            lv = ($urandom_range(3) == 0) ? LW'($urandom) : elv;
            run_burst(st, AW'(sz), la, lv);
        end
        ready_mode = 0;
        wait_drain("t5");
        check_errs("t5");

        // Reset while a line sits in the buffer.
        ready_mode = 2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus_if.mem_req        = 1'b1;
        bus_if.mem_start_addr = 19'h00600;
        bus_if.mem_size_bytes = 19'd96;
        bus_if.mem_data       = rand_line();
        bus_if.last           = 1'b0;
        bus_if.mem_last_valid = 5'd31;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t6_buffered_we", o_sram_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we",      o_sram_we, 0);
        chk("t6_rst_busy",    o_busy, 0);
        chk("t6_rst_gnt",     bus_if.mem_gnt, 0);
        chk("t6_rst_addr",    o_sram_addr, 0);
        bus_if.mem_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        run_burst(19'h00600, 19'd96, 3, 5'd31);
        chk("t6_first_gnt_cycle", first_gnt_c, 1);
        wait_drain("t6");
        check_errs("t6");
        chk("end_busy", o_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
